// File: rtl/minhash_pkg.sv
// minhash_pkg: shared constants and types for the MinHash scheduler.
//   - MurmurHash3_x86_32 multiplier/mix constants and the fixed 4-byte length.
//   - state_t: scheduler FSM states.
//   - rol32: 32-bit rotate-left helper.
package minhash_pkg;

    localparam logic [31:0] C1       = 32'hcc9e2d51;
    localparam logic [31:0] C2       = 32'h1b873593;
    localparam logic [31:0] N        = 32'he6546b64;
    localparam logic [31:0] FMIX1    = 32'h85ebca6b;
    localparam logic [31:0] FMIX2    = 32'hc2b2ae35;
    localparam logic [31:0] LEN_WORD = 32'd4;

    typedef enum logic [1:0] {IDLE, WAIT, HASH, EMIT} state_t;

    function automatic logic [31:0] rol32(input logic [31:0] v, input int unsigned r);
        return (v << r) | (v >> (32 - r));
    endfunction

endpackage

// File: rtl/murmur32_word.sv
// murmur32_word: combinational MurmurHash3_x86_32 of a single 4-byte block.
// Ports:
//   chunk  in  32  data word (the only block, len=4)
//   seed   in  32  hash seed
//   hash   out 32  finalised hash
module murmur32_word
    import minhash_pkg::*;
(
    input  logic [31:0] chunk,
    input  logic [31:0] seed,
    output logic [31:0] hash
);

    logic [31:0] k;
    logic [31:0] h;

    always_comb begin
        k = chunk * C1;
        k = rol32(k, 15);
        k = k * C2;

        h = seed ^ k;
        h = rol32(h, 13);
        h = h * 32'd5 + N;

        // Tail is empty; fold in length then finalise.
        h = h ^ LEN_WORD;
        h = h ^ (h >> 16);
        h = h * FMIX1;
        h = h ^ (h >> 13);
        h = h * FMIX2;
        h = h ^ (h >> 16);

        hash = h;
    end

endmodule

// File: rtl/minhash_sched.sv
// minhash_sched: time-shares one murmur32_word across NUM_HASH seeds to build a
// MinHash signature over a stream of shingles, then streams the minima out.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      pulse in IDLE: clear minima, open a new set
//   shingle_valid/ready/data/last  shingle input handshake
//   sig_valid/ready/idx/data/last  signature output handshake
//   busy                       high whenever the FSM is not IDLE
module minhash_sched
    import minhash_pkg::*;
#(
    parameter int unsigned NUM_HASH  = 4,
    parameter logic [31:0] SEED_BASE = 32'h0000_0000,
    parameter int unsigned IDXW      = $clog2(NUM_HASH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            shingle_valid,
    output logic            shingle_ready,
    input  logic [31:0]     shingle_data,
    input  logic            shingle_last,
    output logic            sig_valid,
    input  logic            sig_ready,
    output logic [IDXW-1:0] sig_idx,
    output logic [31:0]     sig_data,
    output logic            sig_last,
    output logic            busy
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_HASH - 1);

    state_t          state_q;
    logic [IDXW-1:0] cnt_q;
    logic [IDXW-1:0] cnt_inc;
    logic [31:0]     min_q [NUM_HASH];
    logic [31:0]     data_q;
    logic            last_q;
    logic [31:0]     seed;
    logic [31:0]     hv;

    assign cnt_inc = cnt_q + IDXW'(1);
    assign seed    = SEED_BASE + 32'(cnt_q);

    murmur32_word u_hash (
        .chunk (data_q),
        .seed  (seed),
        .hash  (hv)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            data_q        <= '0;
            last_q        <= 1'b0;
            shingle_ready <= 1'b0;
            sig_valid     <= 1'b0;
            sig_idx       <= '0;
            sig_data      <= '0;
            sig_last      <= 1'b0;
            busy          <= 1'b0;
            for (int i = 0; i < NUM_HASH; i++) min_q[i] <= 32'hFFFF_FFFF;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_HASH; i++) min_q[i] <= 32'hFFFF_FFFF;
                        cnt_q         <= '0;
                        state_q       <= WAIT;
                        shingle_ready <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                WAIT: begin
                    // shingle_ready is high throughout WAIT, so valid alone completes the handshake.
                    if (shingle_valid) begin
                        data_q        <= shingle_data;
                        last_q        <= shingle_last;
                        cnt_q         <= '0;
                        state_q       <= HASH;
                        shingle_ready <= 1'b0;
                    end
                end
                HASH: begin
                    if (hv < min_q[cnt_q]) min_q[cnt_q] <= hv;
                    if (cnt_q == LAST_IDX) begin
                        cnt_q <= '0;
                        if (last_q) begin
                            // min_q[0] is already final here since NUM_HASH >= 2.
                            state_q   <= EMIT;
                            sig_valid <= 1'b1;
                            sig_idx   <= '0;
                            sig_data  <= min_q[0];
                            sig_last  <= 1'b0;
                        end else begin
                            state_q       <= WAIT;
                            shingle_ready <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                EMIT: begin
                    if (sig_ready) begin
                        if (cnt_q == LAST_IDX) begin
                            cnt_q     <= '0;
                            state_q   <= IDLE;
                            busy      <= 1'b0;
                            sig_valid <= 1'b0;
                            sig_idx   <= '0;
                            sig_data  <= '0;
                            sig_last  <= 1'b0;
                        end else begin
                            cnt_q    <= cnt_inc;
                            sig_idx  <= cnt_inc;
                            sig_data <= min_q[cnt_inc];
                            sig_last <= (cnt_inc == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
